// File: rtl/up_frame_packer.sv
// Buffers the collector word stream in a FWFT FIFO and emits fixed-length uplink
// frames (header, FRAME_WORDS payload words, XOR checksum trailer) on a ready/valid port.
module up_frame_packer #(
   parameter int          FRAME_WORDS = 8,
   parameter int          FIFO_DEPTH  = 32,
   parameter logic [15:0] SYNC        = 16'hA5A5,
   localparam int         AW          = $clog2(FIFO_DEPTH),
   localparam int         CW          = $clog2(FRAME_WORDS) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_valid,
   input  logic [63:0]   up_data,
   input  logic          tx_ready,
   output logic          tx_valid,
   output logic [63:0]   tx_data,
   output logic          tx_sop,
   output logic          tx_eop,
   output logic [AW:0]   fifo_level,
   output logic [15:0]   overflow_cnt,
   output logic [1:0]    dbg_state
);

   // tx port: a word moves on every edge where tx_valid && tx_ready; while tx_valid is
   // high and tx_ready low, tx_data/tx_sop/tx_eop hold. tx_valid never depends on tx_ready.

   typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

   state_t          state, state_nxt;
   logic [63:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [15:0]     seq;
   logic [63:0]     chk;
   logic [CW-1:0]   word_cnt;
   logic            push, drop, pop, hs;

   // Full check looks at the registered level only, so a same-cycle pop cannot free a slot.
   assign push = data_valid && (fifo_level < (AW+1)'(FIFO_DEPTH));
   assign drop = data_valid && !push;
   assign hs   = tx_valid && tx_ready;
   assign pop  = (state == S_BODY) && tx_ready;

   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= up_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
            2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop && (overflow_cnt != 16'hFFFF))
            overflow_cnt <= overflow_cnt + 16'd1;
      end
   end

   // FSM state register plus the frame bookkeeping it drives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         seq      <= '0;
         chk      <= '0;
         word_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (hs) begin
            case (state)
               S_HEAD: begin
                  chk      <= '0;
                  word_cnt <= '0;
               end
               S_BODY: begin
                  chk      <= chk ^ tx_data;
                  word_cnt <= word_cnt + CW'(1);
               end
               S_TAIL:  seq <= seq + 16'd1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (fifo_level >= (AW+1)'(FRAME_WORDS)) state_nxt = S_HEAD;
         S_HEAD: if (tx_ready) state_nxt = S_BODY;
         S_BODY: if (tx_ready && (word_cnt == CW'(FRAME_WORDS - 1))) state_nxt = S_TAIL;
         S_TAIL: if (tx_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      tx_valid = 1'b0;
      tx_sop   = 1'b0;
      tx_eop   = 1'b0;
      tx_data  = '0;
      case (state)
         S_HEAD: begin
            tx_valid = 1'b1;
            tx_sop   = 1'b1;
            tx_data  = {SYNC, seq, 16'(FRAME_WORDS), 16'h0000};
         end
         S_BODY: begin
            tx_valid = 1'b1;
            tx_data  = mem[rd_ptr];
         end
         S_TAIL: begin
            tx_valid = 1'b1;
            tx_eop   = 1'b1;
            tx_data  = chk;
         end
         default: ;
      endcase
   end

endmodule
